// File: rtl/clock_pkg.sv
// Shared widths, BCD limits and mode encoding for the clock_register time-of-day block.
package clock_pkg;

  localparam int HOURS_W = 6;
  localparam int MIN_W   = 7;
  localparam int SEC_W   = 7;

  localparam logic [7:0] HOURS_MAX  = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_SET = 1'b1
  } mode_e;

endpackage

// File: rtl/clock_register_if.sv
// Signal bundle for one clock_register instance; clk and reset travel separately.
interface clock_register_if;
  import clock_pkg::*;

  logic               i_ena;
  logic               i_1hz_stb;
  logic               i_slow_set_stb;
  logic               i_fast_set_stb;
  logic               i_fast_set;
  logic               i_set_hours;
  logic               i_set_minutes;
  logic [HOURS_W-1:0] o_hours;
  logic [MIN_W-1:0]   o_minutes;
  logic [SEC_W-1:0]   o_seconds;
  logic               o_update_stb;

  modport master (
    output i_ena, i_1hz_stb, i_slow_set_stb, i_fast_set_stb,
    output i_fast_set, i_set_hours, i_set_minutes,
    input  o_hours, o_minutes, o_seconds, o_update_stb
  );

  modport slave (
    input  i_ena, i_1hz_stb, i_slow_set_stb, i_fast_set_stb,
    input  i_fast_set, i_set_hours, i_set_minutes,
    output o_hours, o_minutes, o_seconds, o_update_stb
  );

endinterface

// File: rtl/bcd_counter.sv
// Two-digit BCD counter wrapping MAX -> 00, with synchronous clear and a carry on the wrapping increment.
module bcd_counter #(
  parameter int             W         = 7,
  parameter logic [7:0]     MAX       = 8'h59,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] value,
  output logic         carry
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Any value at or beyond MAX, or with a bad ones digit, recovers to 00.
  function automatic logic [7:0] bcd_next(input logic [7:0] v);
    logic [7:0] r;
    if ((v >= MAX) || (v[3:0] > 4'd9)) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc) begin
      value_d = W'(bcd_next(8'(value_q)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= RESET_VAL;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc && !clear && (8'(value_q) == MAX);

endmodule

// File: rtl/clock_register.sv
// Hours:minutes:seconds BCD time register with run counting, set-mode adjustment and a change strobe.
module clock_register
  import clock_pkg::*;
#(
  parameter logic [HOURS_W-1:0] RESET_HOURS   = 6'h00,
  parameter logic [MIN_W-1:0]   RESET_MINUTES = 7'h00
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_ena,
  input  logic               i_1hz_stb,
  input  logic               i_slow_set_stb,
  input  logic               i_fast_set_stb,
  input  logic               i_fast_set,
  input  logic               i_set_hours,
  input  logic               i_set_minutes,
  output logic [HOURS_W-1:0] o_hours,
  output logic [MIN_W-1:0]   o_minutes,
  output logic [SEC_W-1:0]   o_seconds,
  output logic               o_update_stb
);

  mode_e              mode;
  logic               set_stb;
  logic               sec_inc;
  logic               sec_clear;
  logic               sec_chg;
  logic               min_inc;
  logic               hr_inc;
  logic               sec_carry;
  logic               min_carry;
  logic               hr_carry;
  logic [HOURS_W-1:0] hours;
  logic [MIN_W-1:0]   minutes;
  logic [SEC_W-1:0]   seconds;
  logic               update_d;
  logic               update_q;

  // Set mode is purely a function of the two set levels; no mode state is kept.
  always_comb begin
    mode = (i_set_hours || i_set_minutes) ? MODE_SET : MODE_RUN;
  end

  always_comb begin
    set_stb   = i_fast_set ? i_fast_set_stb : i_slow_set_stb;
    sec_inc   = i_ena && (mode == MODE_RUN) && i_1hz_stb;
    sec_clear = i_ena && i_set_minutes;
    sec_chg   = sec_clear ? (seconds != '0) : sec_inc;
    if (mode == MODE_RUN) begin
      min_inc = sec_carry;
      hr_inc  = min_carry;
    end else begin
      // Set increments never ripple: the minutes carry is ignored here.
      min_inc = i_ena && set_stb && i_set_minutes;
      hr_inc  = i_ena && set_stb && i_set_hours;
    end
    update_d = sec_chg || min_inc || hr_inc || hr_carry;
  end

  bcd_counter #(
    .W         (SEC_W),
    .MAX       (MINSEC_MAX),
    .RESET_VAL ({SEC_W{1'b0}})
  ) u_seconds (
    .clk   (i_clk),
    .rst   (i_reset),
    .inc   (sec_inc),
    .clear (sec_clear),
    .value (seconds),
    .carry (sec_carry)
  );

  bcd_counter #(
    .W         (MIN_W),
    .MAX       (MINSEC_MAX),
    .RESET_VAL (RESET_MINUTES)
  ) u_minutes (
    .clk   (i_clk),
    .rst   (i_reset),
    .inc   (min_inc),
    .clear (1'b0),
    .value (minutes),
    .carry (min_carry)
  );

  bcd_counter #(
    .W         (HOURS_W),
    .MAX       (HOURS_MAX),
    .RESET_VAL (RESET_HOURS)
  ) u_hours (
    .clk   (i_clk),
    .rst   (i_reset),
    .inc   (hr_inc),
    .clear (1'b0),
    .value (hours),
    .carry (hr_carry)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      update_q <= 1'b0;
    end else begin
      update_q <= update_d;
    end
  end

  assign o_hours      = hours;
  assign o_minutes    = minutes;
  assign o_seconds    = seconds;
  assign o_update_stb = update_q;

endmodule

// File: tb/tb_clock_register.sv
// Directed bench for clock_register: instance A uses default reset time, instance B resets to 23:59.
module tb_clock_register;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  clock_register_if if_a ();
  clock_register_if if_b ();

  clock_register dut_a (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_ena          (if_a.i_ena),
    .i_1hz_stb      (if_a.i_1hz_stb),
    .i_slow_set_stb (if_a.i_slow_set_stb),
    .i_fast_set_stb (if_a.i_fast_set_stb),
    .i_fast_set     (if_a.i_fast_set),
    .i_set_hours    (if_a.i_set_hours),
    .i_set_minutes  (if_a.i_set_minutes),
    .o_hours        (if_a.o_hours),
    .o_minutes      (if_a.o_minutes),
    .o_seconds      (if_a.o_seconds),
    .o_update_stb   (if_a.o_update_stb)
  );

  clock_register #(
    .RESET_HOURS   (6'h23),
    .RESET_MINUTES (7'h59)
  ) dut_b (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_ena          (if_b.i_ena),
    .i_1hz_stb      (if_b.i_1hz_stb),
    .i_slow_set_stb (if_b.i_slow_set_stb),
    .i_fast_set_stb (if_b.i_fast_set_stb),
    .i_fast_set     (if_b.i_fast_set),
    .i_set_hours    (if_b.i_set_hours),
    .i_set_minutes  (if_b.i_set_minutes),
    .o_hours        (if_b.o_hours),
    .o_minutes      (if_b.o_minutes),
    .o_seconds      (if_b.o_seconds),
    .o_update_stb   (if_b.o_update_stb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) * 16) + (n % 10));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input bit b, input string tag,
                          input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    if (b) begin
      chk({tag, "_h"}, 8'(if_b.o_hours), h);
      chk({tag, "_m"}, 8'(if_b.o_minutes), m);
      chk({tag, "_s"}, 8'(if_b.o_seconds), s);
    end else begin
      chk({tag, "_h"}, 8'(if_a.o_hours), h);
      chk({tag, "_m"}, 8'(if_a.o_minutes), m);
      chk({tag, "_s"}, 8'(if_a.o_seconds), s);
    end
  endtask

  function automatic logic [7:0] upd(input bit b);
    return b ? 8'(if_b.o_update_stb) : 8'(if_a.o_update_stb);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_1hz(input bit b);
    if (b) if_b.i_1hz_stb = 1'b1; else if_a.i_1hz_stb = 1'b1;
    tick();
    if_a.i_1hz_stb = 1'b0;
    if_b.i_1hz_stb = 1'b0;
  endtask

  task automatic pulse_slow(input bit b);
    if (b) if_b.i_slow_set_stb = 1'b1; else if_a.i_slow_set_stb = 1'b1;
    tick();
    if_a.i_slow_set_stb = 1'b0;
    if_b.i_slow_set_stb = 1'b0;
  endtask

  task automatic pulse_fast(input bit b);
    if (b) if_b.i_fast_set_stb = 1'b1; else if_a.i_fast_set_stb = 1'b1;
    tick();
    if_a.i_fast_set_stb = 1'b0;
    if_b.i_fast_set_stb = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    if_a.i_ena = 1'b1; if_a.i_1hz_stb = 1'b0; if_a.i_slow_set_stb = 1'b0;
    if_a.i_fast_set_stb = 1'b0; if_a.i_fast_set = 1'b0;
    if_a.i_set_hours = 1'b0; if_a.i_set_minutes = 1'b0;
    if_b.i_ena = 1'b1; if_b.i_1hz_stb = 1'b0; if_b.i_slow_set_stb = 1'b0;
    if_b.i_fast_set_stb = 1'b0; if_b.i_fast_set = 1'b0;
    if_b.i_set_hours = 1'b0; if_b.i_set_minutes = 1'b0;

    // Reset values
    tick();
    tick();
    rst = 1'b0;
    chk_time(0, "rst_a", 8'h00, 8'h00, 8'h00);
    chk("rst_a_upd", upd(0), 8'h00);
    chk_time(1, "rst_b", 8'h23, 8'h59, 8'h00);
    chk("rst_b_upd", upd(1), 8'h00);

    // 60 seconds strobes roll into one minute, one update pulse per strobe
    for (int i = 1; i <= 60; i++) begin
      pulse_1hz(0);
      chk("run_upd", upd(0), 8'h01);
      chk("run_sec", 8'(if_a.o_seconds), bcd(i % 60));
    end
    tick();
    chk("run_idle_upd", upd(0), 8'h00);
    chk_time(0, "run_60", 8'h00, 8'h01, 8'h00);

    // Disabled: strobes dropped, no update pulses
    if_a.i_ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulse_1hz(0);
      chk("dis_upd", upd(0), 8'h00);
    end
    tick();
    chk("dis_late_upd", upd(0), 8'h00);
    chk_time(0, "dis_hold", 8'h00, 8'h01, 8'h00);
    if_a.i_ena = 1'b1;
    pulse_1hz(0);
    chk("reen_upd", upd(0), 8'h01);
    chk_time(0, "reen", 8'h00, 8'h01, 8'h01);

    // Minute setting on the slow strobe; fast and seconds strobes ignored
    if_a.i_set_minutes = 1'b1;
    tick();
    chk("setm_clr_upd", upd(0), 8'h01);
    chk("setm_clr_sec", 8'(if_a.o_seconds), 8'h00);
    tick();
    chk("setm_forced00_upd", upd(0), 8'h00);
    for (int i = 0; i < 3; i++) begin
      pulse_slow(0);
      chk("setm_slow_upd", upd(0), 8'h01);
    end
    for (int i = 0; i < 3; i++) begin
      pulse_fast(0);
      chk("setm_fast_ign_upd", upd(0), 8'h00);
    end
    for (int i = 0; i < 10; i++) begin
      pulse_1hz(0);
      chk("setm_1hz_ign_upd", upd(0), 8'h00);
    end
    chk_time(0, "setm", 8'h00, 8'h04, 8'h00);
    if_a.i_fast_set = 1'b1;
    pulse_fast(0);
    chk("setm_fastsel_upd", upd(0), 8'h01);
    pulse_slow(0);
    chk("setm_slow_ign_upd", upd(0), 8'h00);
    chk_time(0, "setm_fast", 8'h00, 8'h05, 8'h00);
    if_a.i_set_minutes = 1'b0;
    if_a.i_fast_set    = 1'b0;

    // Full-day rollover on B
    for (int i = 1; i <= 59; i++) pulse_1hz(1);
    chk_time(1, "b_235959", 8'h23, 8'h59, 8'h59);
    pulse_1hz(1);
    chk_time(1, "b_rollover", 8'h00, 8'h00, 8'h00);
    chk("b_rollover_upd", upd(1), 8'h01);

    // Set-mode wraps do not carry
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_time(1, "b_rst2", 8'h23, 8'h59, 8'h00);
    if_b.i_set_minutes = 1'b1;
    pulse_slow(1);
    chk_time(1, "b_setm_wrap", 8'h23, 8'h00, 8'h00);
    if_b.i_set_minutes = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_b.i_set_hours   = 1'b1;
    if_b.i_set_minutes = 1'b1;
    pulse_slow(1);
    chk_time(1, "b_setboth_wrap", 8'h00, 8'h00, 8'h00);
    chk("b_setboth_upd", upd(1), 8'h01);
    if_b.i_set_hours   = 1'b0;
    if_b.i_set_minutes = 1'b0;

    // Reset coincident with a carrying strobe leaves no residue
    for (int i = 1; i <= 59; i++) pulse_1hz(0);
    chk_time(0, "a_000059", 8'h00, 8'h00, 8'h59);
    rst = 1'b1;
    if_a.i_1hz_stb = 1'b1;
    tick();
    rst = 1'b0;
    if_a.i_1hz_stb = 1'b0;
    chk_time(0, "rst_mid", 8'h00, 8'h00, 8'h00);
    chk("rst_mid_upd", upd(0), 8'h00);
    tick();
    chk_time(0, "rst_after", 8'h00, 8'h00, 8'h00);
    chk("rst_after_upd", upd(0), 8'h00);
    pulse_1hz(0);
    chk_time(0, "rst_fresh", 8'h00, 8'h00, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
